// File: rtl/summation_sequencer.sv
// Request sequencer around the iterative summation core: buffers N requests,
// restarts the core for each one, captures the final sum and hands {N, sum}
// downstream. N=0 and N=1 are answered locally because the core never
// terminates for them.
module summation_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int NW         = 4,
    parameter int SW         = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] in_n,
    output logic          core_reset,
    output logic [NW-1:0] core_n,
    input  logic [SW-1:0] core_sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] out_n,
    output logic [SW-1:0] out_sum,
    output logic          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [NW:0]   CNT_ONE = {{NW{1'b0}}, 1'b1};
    localparam logic [NW-1:0] N_TWO   = NW'(2);

    logic [NW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [1:0]    state;
    logic [NW:0]   wait_cnt;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [NW-1:0] head;
    logic          head_short;
    logic          capture;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready is forced low for as long as reset is held.
    assign in_ready   = reset & ~fifo_full;
    assign push       = in_valid & in_ready;
    assign pop        = (state == ST_IDLE) & ~fifo_empty;
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign head_short = (head < N_TWO);

    // Core sum is final in the cycle the counter reaches N+1.
    assign capture    = (state == ST_WAIT) &&
                        (wait_cnt == ({1'b0, core_n} + CNT_ONE));

    assign busy       = (state != ST_IDLE) | ~fifo_empty;

    // Request storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= in_n;
        end
    end

    // FIFO pointers; reset flushes any queued requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Sequencer: pop, restart core, count to completion, capture, hand off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            core_n     <= '0;
            wait_cnt   <= '0;
            out_valid  <= 1'b0;
            out_n      <= '0;
            out_sum    <= '0;
        end else begin
            core_reset <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head_short) begin
                            out_n     <= head;
                            out_sum   <= {{(SW-NW){1'b0}}, head};
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            core_n     <= head;
                            core_reset <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture) begin
                        out_sum   <= core_sum;
                        out_n     <= core_n;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_summation_sequencer.sv
// Bench for summation_sequencer with a behavioural model of the iterative
// core and a scoreboard of expected {N, sum} results.
module tb_summation_sequencer;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_n;
    logic       core_reset;
    logic [3:0] core_n;
    logic [6:0] core_sum;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_n;
    logic [6:0] out_sum;
    logic       busy;

    summation_sequencer #(.FIFO_DEPTH(4), .NW(4), .SW(7)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n),
        .core_reset(core_reset), .core_n(core_n), .core_sum(core_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_n(out_n), .out_sum(out_sum), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Core model: sum is only correct in the (N+2)th cycle after restart and
    // keeps changing afterwards, so an early or late capture is visible.
    logic [6:0] m_sum;
    logic [6:0] m_i;
    always @(posedge clock) begin
        if (core_reset) begin
            m_sum <= 7'd0;
            m_i   <= 7'd0;
        end else begin
            m_sum <= m_sum + m_i;
            m_i   <= m_i + 7'd1;
        end
    end
    assign core_sum = m_sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cr_cnt = 0;
    int n_out  = 0;
    logic last_fi;
    logic [10:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] tri_sum(input logic [3:0] n);
        int v;
        v = int'(n) * (int'(n) + 1) / 2;
        return v[6:0];
    endfunction

    // One clock: sample handshakes before the edge, update scoreboard.
    task automatic tick();
        logic fi, fo;
        logic [3:0] on;
        logic [6:0] os;
        logic [10:0] e;
        fi = in_valid & in_ready;
        fo = out_valid & out_ready;
        on = out_n;
        os = out_sum;
        if (core_reset) cr_cnt++;
        if (fo) begin
            chk("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_n", on, e[10:7]);
                chk("out_sum", os, e[6:0]);
            end
            n_out++;
        end
        if (fi) sb.push_back({in_n, tri_sum(in_n)});
        last_fi = fi;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [3:0] n, output int acc);
        int g;
        in_valid = 1'b1;
        in_n     = n;
        g = 0;
        do begin
            tick();
            g++;
        end while (!last_fi && g < 200);
        chk("send_accepted", last_fi, 1);
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_out(output int at);
        int g;
        g = 0;
        while (!out_valid && g < 200) begin
            tick();
            g++;
        end
        at = cyc;
    endtask

    task automatic check_latency(input string tag, input logic [3:0] n, input int lat);
        int a, e;
        send(n, a);
        wait_out(e);
        chk(tag, e - a, lat);
        tick();
    endtask

    initial begin
        int a, e, cn_err, base;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_n      = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_n", core_n, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_n", out_n, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        tick();
        chk("rel_core_reset", core_reset, 0);
        tick();

        // N=5: latency, single restart pulse, core_n held through capture
        cr_cnt = 0;
        cn_err = 0;
        send(4'd5, a);
        while (!out_valid && cyc < a + 200) begin
            tick();
            if (core_n != 4'd5) cn_err++;
        end
        chk("lat_n5", cyc - a, 9);
        chk("core_n_n5", core_n, 5);
        chk("core_n_stable", cn_err, 0);
        chk("core_reset_pulse", cr_cnt, 1);
        tick();

        check_latency("lat_n15", 4'd15, 19);
        check_latency("lat_n2", 4'd2, 6);

        // Bypass values never touch the core
        cr_cnt = 0;
        check_latency("lat_n0", 4'd0, 1);
        check_latency("lat_n1", 4'd1, 1);
        chk("bypass_no_core_reset", cr_cnt, 0);

        // Back-pressure: fill FIFO while first result waits in DONE
        out_ready = 1'b0;
        base = n_out;
        for (int k = 3; k <= 7; k++) send(4'(k), a);
        in_valid = 1'b1;
        in_n     = 4'd8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_in_ready", in_ready, 0);
        end
        wait_out(e);
        for (int k = 0; k < 3; k++) begin
            chk("done_hold_valid", out_valid, 1);
            chk("done_hold_sum", out_sum, 6);
            tick();
        end
        out_ready = 1'b1;
        e = 0;
        while (!last_fi && e < 200) begin
            tick();
            e++;
        end
        in_valid = 1'b0;
        e = 0;
        while (sb.size() != 0 && e < 500) begin
            tick();
            e++;
        end
        chk("full_drain_count", n_out - base, 6);

        // Reset mid-WAIT with two requests queued
        send(4'd9, a);
        send(4'd3, a);
        send(4'd4, a);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_core_reset", core_reset, 1);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", busy, 0);
        check_latency("lat_after_rst_n4", 4'd4, 8);

        // Random N with random downstream stalls
        for (int r = 0; r < 40; r++) begin
            in_valid = 1'b1;
            in_n     = 4'($urandom_range(0, 15));
            e = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                e++;
            end while (!last_fi && e < 300);
            chk("rand_accepted", last_fi, 1);
        end
        in_valid = 1'b0;
        e = 0;
        while ((sb.size() != 0 || busy) && e < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            e++;
        end
        chk("rand_drain", sb.size(), 0);
        chk("rand_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/summation_sequencer.md
Name: summation_sequencer

Overview:
Front-end and result-capture stage wrapped around the iterative summation core, which computes the sum of i for i = 1..N with a 4-bit N and a 7-bit sum.
- Accepts N requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues each request to the core with a deterministic restart, then holds the core's N stable for the whole computation.
- Samples the core's sum at the one cycle it is final and presents {N, sum} downstream over valid/ready.
- Resolves N=0 and N=1 locally, because the core does not terminate for those values.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2)
NW, 4, width of N
SW, 7, width of sum (max 15·16/2 = 120)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  FIFO not full
in_n  in  NW  requested N
core_reset  out  1  active-high synchronous restart to core
core_n  out  NW  N driven to core (registered)
core_sum  in  SW  core sum output
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_n  out  NW  N of the result
out_sum  out  SW  sum of 1..out_n
busy  out  1  state ≠ IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, in_ready=0 while asserted then 1, core_reset=1 while asserted, core_n=0, out_valid=0, out_n=0, out_sum=0, busy=0, wait counter=0.
- FIFO push on in_valid&in_ready; in_ready = !full. Pop only in IDLE. Push into a full FIFO is impossible. Simultaneous push/pop when full is not allowed because in_ready=0.
- States and transitions:
  - IDLE: if FIFO non-empty, pop entry n.
    - n≥2: core_n←n, go to ISSUE.
    - n∈{0,1}: out_n←n, out_sum←n, out_valid←1, go to DONE (core untouched).
  - ISSUE (1 cycle): core_reset=1, core_n held. Wait counter←0. Go to WAIT.
  - WAIT: core_reset=0, core_n held. Counter increments each cycle.
    - In the cycle where counter == core_n+1 (the (N+2)th cycle after ISSUE, counting ISSUE as cycle 0), core_sum is final.
    - At that cycle's closing edge: out_sum←core_sum, out_n←core_n, out_valid←1, go to DONE.
  - DONE: hold outputs. On out_valid&out_ready, clear out_valid and go to IDLE.
- Latency, with A = acceptance edge into an empty FIFO and sequencer IDLE:
  - Bypass (N=0/1): out_valid high after edge A+1.
  - Core path: out_valid high after edge A+N+4 (N=2 → A+6, N=15 → A+19).
- One request in flight. No new ISSUE until DONE has handshaken. FIFO keeps accepting during WAIT/DONE until full.
- core_n stays constant from ISSUE through capture. It is only changed in IDLE.
- Width: out_sum is SW bits; the max value 120 fits and no wrap is possible. The wait counter is NW+1 bits.
- Async reset mid-WAIT/DONE: the in-flight result is discarded and the FIFO is flushed. core_reset stays high during reset, so the core restarts cleanly. First result after release follows the normal latency.
- out_ready held high continuously: back-to-back results are separated by at least one IDLE cycle.

Test Plan:
- Reset then push N=5 with out_ready=1 → out_valid after edge A+9, out_n=5, out_sum=15; core_reset high exactly one cycle; core_n=5 stable through capture.
- Push N=15 → out_sum=120 after edge A+19; then N=2 → out_sum=3, 6 edges after its pop-ready acceptance.
- Push N=0 and N=1 → out_sum=0 and 1, each out_valid after edge A+1; core_reset never asserted.
- Hold out_ready=0, push 6 requests (N=3,4,5,6,7,8) → in_ready=0 once the FIFO is full; the first result (6) stays stable in DONE. Release out_ready → results 6,10,15,21,28,36 in order, none lost.
- Assert reset low during WAIT of N=9 with 2 queued → out_valid=0 immediately, FIFO empty, busy=0. After release, push N=4 → out_sum=10.
- Randomised N 0..15 with random out_ready stalls → every out_sum = N(N+1)/2, order preserved.
